// File: rtl/jtdsp16_do_cache.sv
// DO/REDO loop cache: records the loop body while the decoder fetches it from ROM,
// then replays it from local storage for the remaining iterations while holding the ROM PC.
module jtdsp16_do_cache #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          do_start,
    input  logic [10:0]   do_data,
    input  logic          fetch,
    input  logic [DW-1:0] rom_dout,
    output logic [DW-1:0] cache_dout,
    output logic          up_xcache,
    output logic          pc_hold,
    output logic          no_int,
    output logic          fault
);
    localparam int unsigned DEPTH = 15;
    localparam int unsigned PW    = 4;
    localparam int unsigned KW    = 7;

    typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wr, wr_nxt, rd, rd_nxt, last_ni, last_ni_nxt, last_idx, ni;
    logic [KW-1:0] iter, iter_nxt, k;
    logic          fault_nxt, up_nxt, noint_nxt, mem_we;
    logic [DW-1:0] mem [DEPTH];

    assign ni       = do_data[10:7];
    assign k        = do_data[6:0];
    assign last_idx = last_ni - PW'(1);

    // State, pointers, counter and registered outputs; everything frozen while cen is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr        <= '0;
            rd        <= '0;
            last_ni   <= '0;
            iter      <= '0;
            fault     <= 1'b0;
            up_xcache <= 1'b0;
            pc_hold   <= 1'b0;
            no_int    <= 1'b0;
        end else if (cen) begin
            state     <= state_nxt;
            wr        <= wr_nxt;
            rd        <= rd_nxt;
            last_ni   <= last_ni_nxt;
            iter      <= iter_nxt;
            fault     <= fault_nxt;
            up_xcache <= up_nxt;
            pc_hold   <= up_nxt;
            no_int    <= noint_nxt;
        end
    end

    // Next state and loop bookkeeping
    always_comb begin
        state_nxt   = state;
        wr_nxt      = wr;
        rd_nxt      = rd;
        last_ni_nxt = last_ni;
        iter_nxt    = iter;
        case (state)
            IDLE: begin
                if (do_start && k != '0) begin
                    if (ni != '0) begin
                        last_ni_nxt = ni;
                        wr_nxt      = '0;
                        iter_nxt    = k;
                        state_nxt   = FILL;
                    end else if (last_ni != '0) begin
                        rd_nxt    = '0;
                        iter_nxt  = k;
                        state_nxt = REPLAY;
                    end
                end
            end
            FILL: begin
                if (fetch) begin
                    wr_nxt = wr + PW'(1);
                    if (wr == last_idx) begin
                        iter_nxt  = iter - KW'(1);
                        rd_nxt    = '0;
                        state_nxt = (iter == KW'(1)) ? IDLE : REPLAY;
                    end
                end
            end
            REPLAY: begin
                if (fetch) begin
                    if (rd == last_idx) begin
                        rd_nxt   = '0;
                        iter_nxt = iter - KW'(1);
                        if (iter == KW'(1)) state_nxt = IDLE;
                    end else begin
                        rd_nxt = rd + PW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; nested DO, K=0 and REDO without a recorded body all fault
    always_comb begin
        fault_nxt = 1'b0;
        if (do_start) begin
            if (state != IDLE)                   fault_nxt = 1'b1;
            else if (k == '0)                    fault_nxt = 1'b1;
            else if (ni == '0 && last_ni == '0)  fault_nxt = 1'b1;
        end
        up_nxt    = (state_nxt == REPLAY);
        noint_nxt = (state_nxt != IDLE);
        mem_we    = cen && fetch && (state == FILL);
    end

    // Body storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr] <= rom_dout;
    end

    always_comb begin
        cache_dout = '0;
        if (up_xcache) cache_dout = mem[rd];
    end
endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Directed per-cycle vector bench for the DO/REDO loop cache, plus an async-reset sequence.
module tb_jtdsp16_do_cache;
    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] WA = 16'hA001;
    localparam logic [DW-1:0] WB = 16'hB002;
    localparam logic [DW-1:0] WC = 16'hC003;

    logic          clk = 1'b0;
    logic          rst, cen, do_start, fetch;
    logic [10:0]   do_data;
    logic [DW-1:0] rom_dout, cache_dout;
    logic          up_xcache, pc_hold, no_int, fault;

    typedef struct {
        logic          rst;
        logic          cen;
        logic          ds;
        logic [10:0]   dd;
        logic          fetch;
        logic [DW-1:0] rom;
        logic          up;
        logic          hold;
        logic          noint;
        logic          flt;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    jtdsp16_do_cache #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .do_start   (do_start),
        .do_data    (do_data),
        .fetch      (fetch),
        .rom_dout   (rom_dout),
        .cache_dout (cache_dout),
        .up_xcache  (up_xcache),
        .pc_hold    (pc_hold),
        .no_int     (no_int),
        .fault      (fault)
    );

    task automatic add(input logic r, input logic c, input logic s, input logic [10:0] d,
                       input logic f, input logic [DW-1:0] w, input logic eu, input logic eh,
                       input logic en, input logic ef, input logic [DW-1:0] ed);
        vec_t v;
        v.rst = r; v.cen = c; v.ds = s; v.dd = d; v.fetch = f; v.rom = w;
        v.up = eu; v.hold = eh; v.noint = en; v.flt = ef; v.dout = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic eu, input logic eh, input logic en,
                         input logic ef, input logic [DW-1:0] ed);
        applied++;
        if (up_xcache !== eu || pc_hold !== eh || no_int !== en || fault !== ef || cache_dout !== ed) begin
            miscompares++;
            $display("FAIL %s: got up=%b hold=%b noint=%b fault=%b dout=%h, want up=%b hold=%b noint=%b fault=%b dout=%h",
                     name, up_xcache, pc_hold, no_int, fault, cache_dout, eu, eh, en, ef, ed);
        end
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; cen = vecs[i].cen; do_start = vecs[i].ds;
            do_data = vecs[i].dd; fetch = vecs[i].fetch; rom_dout = vecs[i].rom;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), vecs[i].up, vecs[i].hold, vecs[i].noint, vecs[i].flt, vecs[i].dout);
        end
        vecs.delete();
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; do_start = 1'b0; do_data = '0; fetch = 1'b0; rom_dout = '0;

        // reset, then DO NI=3 K=2: fill A,B,C then one replay pass
        add(1,1,0,11'h000,0,'0,   0,0,0,0,'0);
        add(0,1,0,11'h000,0,'0,   0,0,0,0,'0);
        add(0,1,1,11'h182,0,'0,   0,0,1,0,'0);
        add(0,1,0,11'h000,1,WA,   0,0,1,0,'0);
        add(0,1,0,11'h000,1,WB,   0,0,1,0,'0);
        add(0,1,0,11'h000,1,WC,   1,1,1,0,WA);
        add(0,1,0,11'h000,1,'0,   1,1,1,0,WB);
        add(0,1,0,11'h000,1,'0,   1,1,1,0,WC);
        add(0,1,0,11'h000,1,'0,   0,0,0,0,'0);
        // REDO K=3: three passes from the cache, no fill
        add(0,1,1,11'h003,0,'0,   1,1,1,0,WA);
        for (int p = 0; p < 3; p++) begin
            add(0,1,0,11'h000,1,'0, 1,1,1,0,WB);
            add(0,1,0,11'h000,1,'0, 1,1,1,0,WC);
            if (p < 2) add(0,1,0,11'h000,1,'0, 1,1,1,0,WA);
        end
        add(0,1,0,11'h000,1,'0,   0,0,0,0,'0);
        // REDO K=1 with a two-cycle decoder stall on B
        add(0,1,1,11'h001,0,'0,   1,1,1,0,WA);
        add(0,1,0,11'h000,1,'0,   1,1,1,0,WB);
        add(0,1,0,11'h000,0,'0,   1,1,1,0,WB);
        add(0,1,0,11'h000,0,'0,   1,1,1,0,WB);
        add(0,1,0,11'h000,1,'0,   1,1,1,0,WC);
        add(0,1,0,11'h000,1,'0,   0,0,0,0,'0);
        // do_start with cen low is ignored
        add(0,0,1,11'h001,1,'0,   0,0,0,0,'0);
        // nested DO during fill and on the final replay fetch; cen-low hold in replay
        add(0,1,1,11'h182,0,'0,   0,0,1,0,'0);
        add(0,1,0,11'h000,1,WA,   0,0,1,0,'0);
        add(0,1,1,11'h182,1,WB,   0,0,1,1,'0);
        add(0,1,0,11'h000,1,WC,   1,1,1,0,WA);
        add(0,0,0,11'h000,1,'0,   1,1,1,0,WA);
        add(0,1,0,11'h000,1,'0,   1,1,1,0,WB);
        add(0,1,0,11'h000,1,'0,   1,1,1,0,WC);
        add(0,1,1,11'h003,1,'0,   0,0,0,1,'0);
        add(0,1,0,11'h000,0,'0,   0,0,0,0,'0);
        // DO with K=0
        add(0,1,1,11'h180,0,'0,   0,0,0,1,'0);
        add(0,1,0,11'h000,0,'0,   0,0,0,0,'0);
        // DO NI=15 K=1: fill only, then REDO K=1 replays all 15 words
        add(0,1,1,11'h781,0,'0,   0,0,1,0,'0);
        for (int i = 0; i < 14; i++) add(0,1,0,11'h000,1,DW'(16'h5000 + i), 0,0,1,0,'0);
        add(0,1,0,11'h000,1,16'h500E, 0,0,0,0,'0);
        add(0,1,1,11'h001,0,'0,   1,1,1,0,16'h5000);
        for (int i = 1; i < 15; i++) add(0,1,0,11'h000,1,'0, 1,1,1,0,DW'(16'h5000 + i));
        add(0,1,0,11'h000,1,'0,   0,0,0,0,'0);
        // reset, then REDO faults
        add(1,1,0,11'h000,0,'0,   0,0,0,0,'0);
        add(0,1,1,11'h002,0,'0,   0,0,0,1,'0);
        add(0,1,0,11'h000,0,'0,   0,0,0,0,'0);
        run_vecs("table");

        // DO NI=3 K=3, into the second iteration, then async reset mid-cycle
        add(0,1,1,11'h183,0,'0,   0,0,1,0,'0);
        add(0,1,0,11'h000,1,WA,   0,0,1,0,'0);
        add(0,1,0,11'h000,1,WB,   0,0,1,0,'0);
        add(0,1,0,11'h000,1,WC,   1,1,1,0,WA);
        add(0,1,0,11'h000,1,'0,   1,1,1,0,WB);
        run_vecs("pre_rst");
        @(negedge clk);
        fetch = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst", 0, 0, 0, 0, '0);
        @(negedge clk);
        rst = 1'b0;
        add(0,1,1,11'h003,0,'0,   0,0,0,1,'0);
        add(0,1,0,11'h000,0,'0,   0,0,0,0,'0);
        run_vecs("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
